// File: rtl/balls_collision_detector_if.sv
// Bus between the frame logic and balls_collision_detector.
//   master : drives startOfFrame and the ball position/speed vectors, receives results
//   slave  : the detector; receives the ball vectors, drives pair reports and status
//   startOfFrame                  one-cycle scan request
//   topLeftX_VEC / topLeftY_VEC   per-ball signed positions
//   Xspeed_VEC / Yspeed_VEC       per-ball signed speeds
//   balls_collide                 pair bits, valid only with col_valid
//   Balls_col_ID                  [0]=lower ID, [1]=higher ID of last reported pair
//   col_valid / busy / scan_done / frame_overrun   status
interface balls_collision_detector_if #(
   parameter int unsigned NUM_BALLS = 3,
   parameter int unsigned COORD_W   = 11,
   parameter int unsigned ID_W      = 4
);
   logic                              startOfFrame;
   logic [NUM_BALLS-1:0][COORD_W-1:0] topLeftX_VEC;
   logic [NUM_BALLS-1:0][COORD_W-1:0] topLeftY_VEC;
   logic [NUM_BALLS-1:0][COORD_W-1:0] Xspeed_VEC;
   logic [NUM_BALLS-1:0][COORD_W-1:0] Yspeed_VEC;
   logic [NUM_BALLS-1:0]              balls_collide;
   logic [1:0][ID_W-1:0]              Balls_col_ID;
   logic                              col_valid;
   logic                              busy;
   logic                              scan_done;
   logic                              frame_overrun;

   modport master (
      output startOfFrame, topLeftX_VEC, topLeftY_VEC, Xspeed_VEC, Yspeed_VEC,
      input  balls_collide, Balls_col_ID, col_valid, busy, scan_done, frame_overrun
   );

   modport slave (
      input  startOfFrame, topLeftX_VEC, topLeftY_VEC, Xspeed_VEC, Yspeed_VEC,
      output balls_collide, Balls_col_ID, col_valid, busy, scan_done, frame_overrun
   );
endinterface

// File: rtl/balls_collision_detector.sv
// Per-frame pair scanner: snapshots all balls on startOfFrame, then walks every pair
// (i<j) in order and reports pairs that overlap and are closing, one col_valid pulse each.
// A per-pair mask suppresses repeat reports until the pair has separated.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    balls_collision_detector_if.slave (see interface header)
module balls_collision_detector #(
   parameter int unsigned NUM_BALLS = 3,
   parameter int unsigned COORD_W   = 11,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned DIAM_SQ   = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   balls_collision_detector_if.slave     bus
);

   localparam int unsigned NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
   localparam int unsigned IDX_W     = (NUM_BALLS > 2) ? $clog2(NUM_BALLS) : 1;
   localparam int unsigned PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int unsigned DSQ_W     = 2 * (COORD_W + 1);
   localparam int unsigned DOT_W     = 2 * (COORD_W + 2) + 1;
   localparam int unsigned LAST_I    = NUM_BALLS - 2;
   localparam int unsigned LAST_J    = NUM_BALLS - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_EVAL,
      S_REPORT,
      S_DONE
   } state_e;

   state_e                     state_q, state_d;
   logic [IDX_W-1:0]           i_q, i_d, j_q, j_d;
   logic [PAIR_W-1:0]          p_q, p_d;
   logic [NUM_PAIRS-1:0]       mask_q, mask_d;
   logic signed [COORD_W-1:0]  snap_x_q  [NUM_BALLS];
   logic signed [COORD_W-1:0]  snap_y_q  [NUM_BALLS];
   logic signed [COORD_W-1:0]  snap_vx_q [NUM_BALLS];
   logic signed [COORD_W-1:0]  snap_vy_q [NUM_BALLS];
   logic                       snap_ld_c;
   logic [DSQ_W-1:0]           dsq_q;
   logic signed [DOT_W-1:0]    dot_q;

   logic [NUM_BALLS-1:0]       collide_q, collide_d;
   logic [1:0][ID_W-1:0]       id_q, id_d;
   logic                       col_valid_q, col_valid_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       ovr_q, ovr_d;

   // Pair metrics from the snapshot, evaluated in CHECK and registered for EVAL.
   logic signed [DOT_W-1:0]    dx_c, dy_c, dvx_c, dvy_c, dsq_full_c, dot_c;
   logic [DSQ_W-1:0]           dsq_c;

   always_comb begin
      dx_c       = DOT_W'(snap_x_q[j_q])  - DOT_W'(snap_x_q[i_q]);
      dy_c       = DOT_W'(snap_y_q[j_q])  - DOT_W'(snap_y_q[i_q]);
      dvx_c      = DOT_W'(snap_vx_q[j_q]) - DOT_W'(snap_vx_q[i_q]);
      dvy_c      = DOT_W'(snap_vy_q[j_q]) - DOT_W'(snap_vy_q[i_q]);
      dsq_full_c = dx_c * dx_c + dy_c * dy_c;
      dot_c      = dvx_c * dx_c + dvy_c * dy_c;
      // Sum of squares is non-negative and below 2^(DSQ_W-1), so truncation is lossless.
      dsq_c      = DSQ_W'($unsigned(dsq_full_c));
   end

   // Overlap test, hit decision and next pair in scan order.
   logic             touch_c, hit_c, last_pair_c;
   logic [IDX_W-1:0] nxt_i_c, nxt_j_c;

   always_comb begin
      touch_c     = (dsq_q <= DSQ_W'(DIAM_SQ));
      hit_c       = touch_c && dot_q[DOT_W-1] && !mask_q[p_q];
      last_pair_c = (i_q == IDX_W'(LAST_I)) && (j_q == IDX_W'(LAST_J));
      nxt_i_c     = i_q;
      nxt_j_c     = j_q + IDX_W'(1);
      if (j_q == IDX_W'(LAST_J)) begin
         nxt_i_c = i_q + IDX_W'(1);
         nxt_j_c = i_q + IDX_W'(2);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state, pair walk, mask update and Moore output values (registered below).
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      p_d       = p_q;
      mask_d    = mask_q;
      snap_ld_c = 1'b0;
      id_d      = id_q;
      ovr_d     = ovr_q | (bus.startOfFrame && (state_q != S_IDLE));

      case (state_q)
         S_IDLE: begin
            if (bus.startOfFrame) begin
               snap_ld_c = 1'b1;
               i_d       = '0;
               j_d       = IDX_W'(1);
               p_d       = '0;
               state_d   = S_CHECK;
            end
         end
         S_CHECK: state_d = S_EVAL;
         S_EVAL: begin
            if (!touch_c) mask_d[p_q] = 1'b0;
            if (hit_c) begin
               mask_d[p_q] = 1'b1;
               state_d     = S_REPORT;
            end else if (last_pair_c) begin
               state_d = S_DONE;
            end else begin
               i_d     = nxt_i_c;
               j_d     = nxt_j_c;
               p_d     = p_q + PAIR_W'(1);
               state_d = S_CHECK;
            end
         end
         S_REPORT: begin
            if (last_pair_c) begin
               state_d = S_DONE;
            end else begin
               i_d     = nxt_i_c;
               j_d     = nxt_j_c;
               p_d     = p_q + PAIR_W'(1);
               state_d = S_CHECK;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copy lines up with it.
      col_valid_d = (state_d == S_REPORT);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      collide_d   = '0;
      if (col_valid_d) begin
         collide_d = (NUM_BALLS'(1) << i_q) | (NUM_BALLS'(1) << j_q);
         id_d      = {ID_W'(j_q), ID_W'(i_q)};
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_q         <= '0;
         j_q         <= '0;
         p_q         <= '0;
         mask_q      <= '0;
         dsq_q       <= '0;
         dot_q       <= '0;
         collide_q   <= '0;
         id_q        <= '0;
         col_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         for (int b = 0; b < NUM_BALLS; b++) begin
            snap_x_q[b]  <= '0;
            snap_y_q[b]  <= '0;
            snap_vx_q[b] <= '0;
            snap_vy_q[b] <= '0;
         end
      end else begin
         i_q         <= i_d;
         j_q         <= j_d;
         p_q         <= p_d;
         mask_q      <= mask_d;
         collide_q   <= collide_d;
         id_q        <= id_d;
         col_valid_q <= col_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
         if (state_q == S_CHECK) begin
            dsq_q <= dsq_c;
            dot_q <= dot_c;
         end
         if (snap_ld_c) begin
            for (int b = 0; b < NUM_BALLS; b++) begin
               snap_x_q[b]  <= $signed(bus.topLeftX_VEC[b]);
               snap_y_q[b]  <= $signed(bus.topLeftY_VEC[b]);
               snap_vx_q[b] <= $signed(bus.Xspeed_VEC[b]);
               snap_vy_q[b] <= $signed(bus.Yspeed_VEC[b]);
            end
         end
      end
   end

   assign bus.balls_collide = collide_q;
   assign bus.Balls_col_ID  = id_q;
   assign bus.col_valid     = col_valid_q;
   assign bus.busy          = busy_q;
   assign bus.scan_done     = done_q;
   assign bus.frame_overrun = ovr_q;

endmodule

// File: tb/tb_balls_collision_detector.sv
// Directed bench for balls_collision_detector: a reference model predicts each frame's
// reported pairs (with cycle) into a scoreboard queue, popped as col_valid pulses arrive.
module tb_balls_collision_detector;

   localparam int unsigned NB = 3;
   localparam int unsigned CW = 11;
   localparam int unsigned IW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   balls_collision_detector_if #(.NUM_BALLS(NB), .COORD_W(CW), .ID_W(IW)) bus ();

   balls_collision_detector #(
      .NUM_BALLS(NB), .COORD_W(CW), .ID_W(IW), .DIAM_SQ(1024)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   int bx [NB];
   int by [NB];
   int bvx[NB];
   int bvy[NB];
   bit mmask[3];

   typedef struct {
      int cyc;
      int lo;
      int hi;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ball(input int b, input int x, input int y, input int vx, input int vy);
      bx[b] = x; by[b] = y; bvx[b] = vx; bvy[b] = vy;
   endtask

   task automatic drive_balls();
      for (int b = 0; b < NB; b++) begin
         bus.topLeftX_VEC[b] = CW'(bx[b]);
         bus.topLeftY_VEC[b] = CW'(by[b]);
         bus.Xspeed_VEC[b]   = CW'(bvx[b]);
         bus.Yspeed_VEC[b]   = CW'(bvy[b]);
      end
   endtask

   task automatic scramble_inputs();
      for (int b = 0; b < NB; b++) begin
         bus.topLeftX_VEC[b] = CW'($urandom);
         bus.topLeftY_VEC[b] = CW'($urandom);
         bus.Xspeed_VEC[b]   = CW'($urandom);
         bus.Yspeed_VEC[b]   = CW'($urandom);
      end
   endtask

   // Reference model: pair order, hit rule, mask and cycle schedule of one frame.
   task automatic model_frame(output int done_c);
      int   t;
      int   p;
      int   dx, dy, dsq, dot;
      exp_t e;
      t = 1;
      p = 0;
      for (int i = 0; i < NB - 1; i++) begin
         for (int j = i + 1; j < NB; j++) begin
            dx  = bx[j] - bx[i];
            dy  = by[j] - by[i];
            dsq = dx * dx + dy * dy;
            dot = (bvx[j] - bvx[i]) * dx + (bvy[j] - bvy[i]) * dy;
            if (dsq > 1024) begin
               mmask[p] = 1'b0;
               t += 2;
            end else if (dot < 0 && !mmask[p]) begin
               mmask[p] = 1'b1;
               e.cyc = t + 2; e.lo = i; e.hi = j;
               sbq.push_back(e);
               t += 3;
            end else begin
               t += 2;
            end
            p++;
         end
      end
      done_c = t;
   endtask

   // Start a frame at cycle 0, then check every cycle through DONE and one idle cycle.
   task automatic run_frame(input string name);
      int   done_c;
      exp_t e;
      drive_balls();
      @(negedge clk);
      bus.startOfFrame = 1'b1;
      model_frame(done_c);
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      scramble_inputs();
      for (int c = 1; c <= done_c; c++) begin
         if (bus.col_valid) begin
            if (sbq.size() == 0) begin
               chk($sformatf("%s c%0d unexpected col_valid", name, c), 32'(bus.col_valid), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("%s c%0d report cycle", name, c), 32'(c), 32'(e.cyc));
               chk($sformatf("%s c%0d id_lo", name, c), 32'(bus.Balls_col_ID[0]), 32'(e.lo));
               chk($sformatf("%s c%0d id_hi", name, c), 32'(bus.Balls_col_ID[1]), 32'(e.hi));
               chk($sformatf("%s c%0d collide", name, c), 32'(bus.balls_collide),
                   32'((1 << e.lo) | (1 << e.hi)));
            end
         end else begin
            chk($sformatf("%s c%0d collide idle", name, c), 32'(bus.balls_collide), 32'd0);
         end
         chk($sformatf("%s c%0d scan_done", name, c), 32'(bus.scan_done), 32'(c == done_c));
         chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'd1);
         @(negedge clk);
      end
      chk({name, " idle busy"}, 32'(bus.busy), 32'd0);
      chk({name, " idle scan_done"}, 32'(bus.scan_done), 32'd0);
      chk({name, " idle col_valid"}, 32'(bus.col_valid), 32'd0);
      chk({name, " missing reports"}, 32'(sbq.size()), 32'd0);
      chk({name, " frame_overrun"}, 32'(bus.frame_overrun), 32'd0);
      sbq.delete();
   endtask

   task automatic far_apart();
      set_ball(0, 0, 0, 0, 0);
      set_ball(1, 300, 0, 0, 0);
      set_ball(2, 600, 0, 0, 0);
   endtask

   task automatic all_closing();
      set_ball(0, 100, 100, 2, 2);
      set_ball(1, 110, 100, -2, 0);
      set_ball(2, 100, 110, 0, -2);
   endtask

   initial begin
      bit seen;
      bus.startOfFrame = 1'b0;
      far_apart();
      drive_balls();

      // Reset state
      @(negedge clk);
      chk("rst col_valid", 32'(bus.col_valid), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst scan_done", 32'(bus.scan_done), 32'd0);
      chk("rst overrun", 32'(bus.frame_overrun), 32'd0);
      chk("rst collide", 32'(bus.balls_collide), 32'd0);
      chk("rst ids", 32'(bus.Balls_col_ID), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // T1: B0/B1 overlapping and closing
      set_ball(0, 100, 100, 4, 0);
      set_ball(1, 120, 110, -2, 0);
      set_ball(2, 600, 600, 0, 0);
      run_frame("t1");
      // T2: same positions, mask suppresses the repeat
      run_frame("t2");

      // T3: exact contact distance; separate, touch, separate, touch
      set_ball(0, 100, 100, 1, 0);
      set_ball(1, 133, 100, -1, 0);
      run_frame("t3a_dx33");
      set_ball(1, 132, 100, -1, 0);
      run_frame("t3b_dx32");
      set_ball(1, 133, 100, -1, 0);
      run_frame("t3c_dx33");
      set_ball(1, 132, 100, -1, 0);
      run_frame("t3d_dx32");

      // T4: overlapping but separating; mask stays set so a later closing frame is silent
      set_ball(0, 100, 100, -3, 0);
      set_ball(1, 110, 100, 3, 0);
      run_frame("t4a_sep");
      set_ball(0, 100, 100, 3, 0);
      set_ball(1, 110, 100, -3, 0);
      run_frame("t4b_masked");

      // Negative coordinates
      far_apart();
      run_frame("clr1");
      set_ball(0, -20, -5, 3, 0);
      set_ball(1, 0, -5, -1, 0);
      set_ball(2, -900, 500, 0, 0);
      run_frame("neg");

      // T5: all three mutually overlapping and closing
      far_apart();
      run_frame("clr2");
      all_closing();
      run_frame("t5");

      // T6: startOfFrame during a scan, then reset mid-scan
      drive_balls();
      @(negedge clk);
      bus.startOfFrame = 1'b1;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      chk("t6 c1 busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.startOfFrame = 1'b1;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      chk("t6 c3 overrun", 32'(bus.frame_overrun), 32'd1);
      chk("t6 c3 busy", 32'(bus.busy), 32'd1);
      chk("t6 c3 col_valid", 32'(bus.col_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6 rst busy", 32'(bus.busy), 32'd0);
      chk("t6 rst overrun", 32'(bus.frame_overrun), 32'd0);
      chk("t6 rst scan_done", 32'(bus.scan_done), 32'd0);
      for (int k = 0; k < 3; k++) mmask[k] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.scan_done || bus.busy || bus.col_valid) seen = 1'b1;
      end
      chk("t6 no activity after reset", 32'(seen), 32'd0);
      // Mask was cleared by reset: all three pairs report again
      run_frame("t6_after_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
